// File: rtl/word_sequencer_1553_pkg.sv
// pkg_1553: shared definitions for the 1553 word sequencer and its neighbours.
//   - entry field positions of an 18-bit playback entry {csw, dw, word[15:0]}
//   - sequencer state enum
//   - default inter-message gap, also used by the RT response timer
package pkg_1553;

  localparam int ENTRY_W      = 18;
  localparam int CSW_BIT      = 17;
  localparam int DW_BIT       = 16;
  localparam int WORD_MSB     = 15;
  localparam int GAP_CLKS_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_GAP
  } seq_state_e;

  // Exactly one sync bit set marks a playable entry; 00 and 11 are format errors.
  function automatic logic sync_ok(input logic [ENTRY_W-1:0] e);
    return e[CSW_BIT] ^ e[DW_BIT];
  endfunction

endpackage

// File: rtl/word_sequencer_1553_gap_timer.sv
// seq_gap_timer: loadable down-counter with a zero flag.
// Shared by the sequencer for the inter-message gap and the busy timeout.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset (count -> 0)
//   load_i      load load_val_i (wins over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one, saturating at zero
//   zero_o      count is zero
module seq_gap_timer #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/word_sequencer_1553.sv
// word_sequencer_1553: plays 18-bit entries from a synchronous memory into the
// 1553 Manchester encoder, one write strobe per word, with a dead-time gap
// before every command/status word except the first of a run.
// Ports:
//   enc_clk, rst            clock, synchronous active-high reset
//   start, abort            start pulse (idle only), abort level (wins)
//   base_addr, word_count   run parameters, sampled on accepted start
//   mem_addr, mem_rd        entry read port; mem_rdata valid one cycle later
//   mem_rdata               entry {csw, dw, word[15:0]}
//   tx_dword, tx_csw, tx_dw word and one-cycle strobes to the encoder
//   tx_busy                 encoder busy
//   busy, done, err         run active, completion pulse, sticky error
//
// state      | meaning
// IDLE       | waiting for start
// READ       | mem_rd high for the next entry
// LATCH      | mem_rdata valid; decide issue / gap / skip
// ISSUE      | strobe high for one cycle
// WAIT_HI    | waiting for tx_busy to rise (bounded by BUSY_TO)
// WAIT_LO    | encoder busy; next entry prefetched meanwhile
// GAP        | dead time before a command/status word
//
// All outputs are registered from next-state decode, so a transition into a
// state shows its outputs in the cycle that state is occupied.
module word_sequencer_1553
  import pkg_1553::*;
#(
  parameter int ADDR_W   = 9,
  parameter int GAP_CLKS = GAP_CLKS_DEF,
  parameter int BUSY_TO  = 4
) (
  input  logic               enc_clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W-1:0]  word_count,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [ENTRY_W-1:0] mem_rdata,
  output logic [15:0]        tx_dword,
  output logic               tx_csw,
  output logic               tx_dw,
  input  logic               tx_busy,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int TMR_MAX = (GAP_CLKS > BUSY_TO) ? GAP_CLKS : BUSY_TO;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  seq_state_e state_q, state_d;

  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0]  rem_q, rem_d;        // entries not yet read
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic               rvalid_q, rvalid_d;  // mem_rdata valid this cycle
  logic               pf_q, pf_d;          // a prefetch was issued in this WAIT_LO
  logic               issued_q, issued_d;  // a word has gone out in this run

  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_rd_q, mem_rd_d;
  logic [15:0]        tx_dword_q, tx_dword_d;
  logic               tx_csw_q, tx_csw_d;
  logic               tx_dw_q, tx_dw_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               pf_ready;
  logic [ENTRY_W-1:0] iss_entry;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]   tmr_val;

  // Prefetched entry is usable once its read and data cycles have both passed.
  assign pf_ready  = !mem_rd_q && !rvalid_q;
  assign iss_entry = (state_q == ST_LATCH) ? mem_rdata : entry_q;

  // GAP loaded with GAP_CLKS-1 leaves after GAP_CLKS cycles in GAP. The busy
  // timer is loaded on leaving ISSUE so the timeout edge lands BUSY_TO cycles
  // after the strobe edge.
  assign tmr_load = (state_d != state_q) &&
                    ((state_d == ST_GAP) || (state_d == ST_WAIT_HI));
  assign tmr_val  = (state_d == ST_GAP) ? TMR_W'(GAP_CLKS - 1) : TMR_W'(BUSY_TO - 2);
  assign tmr_dec  = (state_q == ST_GAP) || (state_q == ST_WAIT_HI);

  seq_gap_timer #(.W(TMR_W)) u_timer (
    .clk_i      (enc_clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // State and datapath registers
  always_ff @(posedge enc_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      entry_q    <= '0;
      rvalid_q   <= 1'b0;
      pf_q       <= 1'b0;
      issued_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      tx_dword_q <= '0;
      tx_csw_q   <= 1'b0;
      tx_dw_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      entry_q    <= entry_d;
      rvalid_q   <= rvalid_d;
      pf_q       <= pf_d;
      issued_q   <= issued_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      tx_dword_q <= tx_dword_d;
      tx_csw_q   <= tx_csw_d;
      tx_dw_q    <= tx_dw_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (word_count != '0)) state_d = ST_READ;
      end
      ST_READ: state_d = ST_LATCH;
      ST_LATCH: begin
        if (sync_ok(mem_rdata)) begin
          state_d = (mem_rdata[CSW_BIT] && issued_q) ? ST_GAP : ST_ISSUE;
        end else begin
          state_d = (rem_q != '0) ? ST_READ : ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (tx_busy)       state_d = ST_WAIT_LO;
        else if (tmr_zero) state_d = ST_IDLE;
      end
      ST_WAIT_LO: begin
        if (!tx_busy && pf_ready) begin
          if (!pf_q) begin
            state_d = ST_IDLE;
          end else if (sync_ok(entry_q)) begin
            state_d = entry_q[CSW_BIT] ? ST_GAP : ST_ISSUE;
          end else begin
            state_d = (rem_q != '0) ? ST_READ : ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (tmr_zero) state_d = ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Outputs and datapath next values
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    tx_dword_d = '0;
    tx_csw_d   = 1'b0;
    tx_dw_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    pf_d       = pf_q;
    issued_d   = issued_q;
    rvalid_d   = mem_rd_q;
    entry_d    = rvalid_q ? mem_rdata : entry_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d    = 1'b0;
          issued_d = 1'b0;
          if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            mem_rd_d   = 1'b1;
            mem_addr_d = base_addr;
            ptr_d      = base_addr + ADDR_W'(1);
            rem_d      = word_count - ADDR_W'(1);
          end
        end
      end
      ST_LATCH: begin
        if (!sync_ok(mem_rdata)) begin
          err_d = 1'b1;
          if (rem_q == '0) done_d = 1'b1;
        end
      end
      ST_WAIT_HI: begin
        if (tx_busy) begin
          if (rem_q != '0) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = ptr_q;
            ptr_d      = ptr_q + ADDR_W'(1);
            rem_d      = rem_q - ADDR_W'(1);
            pf_d       = 1'b1;
          end
        end else if (tmr_zero) begin
          err_d  = 1'b1;
          done_d = 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy && pf_ready) begin
          if (!pf_q) begin
            done_d = 1'b1;
          end else if (!sync_ok(entry_q)) begin
            err_d = 1'b1;
            if (rem_q == '0) done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Re-read after a skipped entry (from LATCH or WAIT_LO)
    if ((state_d == ST_READ) && (state_q != ST_IDLE)) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = ptr_q;
      ptr_d      = ptr_q + ADDR_W'(1);
      rem_d      = rem_q - ADDR_W'(1);
    end

    if (state_d == ST_ISSUE) begin
      tx_csw_d   = iss_entry[CSW_BIT];
      tx_dw_d    = iss_entry[DW_BIT];
      tx_dword_d = iss_entry[WORD_MSB:0];
      issued_d   = 1'b1;
    end

    if (state_d != ST_WAIT_LO) pf_d = 1'b0;

    // Abort discards whatever this cycle decided, including error events.
    if (abort) begin
      mem_rd_d   = 1'b0;
      tx_csw_d   = 1'b0;
      tx_dw_d    = 1'b0;
      tx_dword_d = '0;
      done_d     = 1'b0;
      err_d      = err_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign tx_dword = tx_dword_q;
  assign tx_csw   = tx_csw_q;
  assign tx_dw    = tx_dw_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_word_sequencer_1553.sv
// Directed testbench for word_sequencer_1553 with a synchronous memory model
// and an encoder model that holds tx_busy for ENC_BUSY cycles per word.
`timescale 1ns/1ps
module tb_word_sequencer_1553;

  localparam int ADDR_W   = 9;
  localparam int GAP_CLKS = 16;
  localparam int BUSY_TO  = 4;
  localparam int ENC_BUSY = 40;

  logic              enc_clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] word_count = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [17:0]       mem_rdata = '0;
  logic [15:0]       tx_dword;
  logic              tx_csw;
  logic              tx_dw;
  logic              tx_busy = 1'b0;
  logic              busy;
  logic              done;
  logic              err;

  logic [17:0] mem [512];
  logic        enc_en = 1'b1;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [15:0]       s_word[$];
  logic              s_csw[$];
  int                s_cyc[$];
  int                falls[$];
  logic [ADDR_W-1:0] rd_addr[$];
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                bad_dword = 0;

  int sb, fb, rb, db;

  word_sequencer_1553 #(.ADDR_W(ADDR_W), .GAP_CLKS(GAP_CLKS), .BUSY_TO(BUSY_TO)) dut (
    .enc_clk    (enc_clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .word_count (word_count),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .tx_dword   (tx_dword),
    .tx_csw     (tx_csw),
    .tx_dw      (tx_dw),
    .tx_busy    (tx_busy),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #250 enc_clk = ~enc_clk;

  always begin
    @(posedge enc_clk);
    cyc = cyc + 1;
  end

  always begin
    @(posedge enc_clk);
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Encoder model: busy rises the edge after the strobe, held ENC_BUSY cycles.
  always begin
    @(negedge enc_clk);
    if ((tx_csw || tx_dw) && enc_en) begin
      @(posedge enc_clk);
      #1 tx_busy = 1'b1;
      repeat (ENC_BUSY) @(posedge enc_clk);
      #1 tx_busy = 1'b0;
      falls.push_back(cyc);
    end
  end

  // Monitor, sampled on the falling edge.
  always begin
    @(negedge enc_clk);
    if (tx_csw || tx_dw) begin
      s_word.push_back(tx_dword);
      s_csw.push_back(tx_csw);
      s_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (mem_rd) rd_addr.push_back(mem_addr);
    if (!tx_csw && !tx_dw && (tx_dword != 16'h0)) bad_dword = bad_dword + 1;
  end

  initial begin
    #(20000 * 500);
    $display("FAIL watchdog simulation did not finish, got cyc=%0d want < 20000", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic snapshot();
    sb = s_word.size();
    fb = falls.size();
    rb = rd_addr.size();
    db = done_cnt;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c, output int n);
    @(negedge enc_clk);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    @(negedge enc_clk);
    start = 1'b0;
    n = cyc;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (busy && (k < budget)) begin
      @(negedge enc_clk);
      k++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_idle_wait busy=1 after %0d cycles, required 0", tag, budget);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge enc_clk);
    checks++;
    if ({mem_addr, mem_rd, tx_dword, tx_csw, tx_dw, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_values addr=%h rd=%b dword=%h csw=%b dw=%b busy=%b done=%b err=%b, required all 0",
               mem_addr, mem_rd, tx_dword, tx_csw, tx_dw, busy, done, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    snapshot();
    mem[0] = {2'b10, 16'h5555};
    mem[1] = {2'b01, 16'hABCD};
    mem[2] = {2'b01, 16'h1234};
    do_start(9'h000, 9'd3, n);
    checks++;
    if ({busy, mem_rd, mem_addr} !== {1'b1, 1'b1, 9'h000}) begin
      errors++;
      $display("FAIL basic_start busy/rd/addr=%b/%b/%h, required 1/1/000", busy, mem_rd, mem_addr);
    end
    wait_idle(400, "basic");
    checks++;
    if (s_word.size() - sb != 3) begin
      errors++;
      $display("FAIL basic_strobe_count got %0d, required 3", s_word.size() - sb);
    end else begin
      checks++;
      if ({s_csw[sb], s_csw[sb+1], s_csw[sb+2]} !== 3'b100 ||
          s_word[sb] !== 16'h5555 || s_word[sb+1] !== 16'hABCD || s_word[sb+2] !== 16'h1234) begin
        errors++;
        $display("FAIL basic_words got %b:%h %b:%h %b:%h, required 1:5555 0:abcd 0:1234",
                 s_csw[sb], s_word[sb], s_csw[sb+1], s_word[sb+1], s_csw[sb+2], s_word[sb+2]);
      end
      checks++;
      if (s_cyc[sb] != n + 2) begin
        errors++;
        $display("FAIL basic_first_latency strobe cycle %0d, required %0d", s_cyc[sb], n + 2);
      end
      checks++;
      if ((s_cyc[sb+1] != falls[fb] + 1) || (s_cyc[sb+2] != falls[fb+1] + 1)) begin
        errors++;
        $display("FAIL basic_dw_turnaround strobes at %0d,%0d, required %0d,%0d",
                 s_cyc[sb+1], s_cyc[sb+2], falls[fb] + 1, falls[fb+1] + 1);
      end
    end
    checks++;
    if (done_cnt - db != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_err done pulses=%0d err=%b, required 1 and 0", done_cnt - db, err);
    end
    checks++;
    if (falls.size() - fb != 3 || done_cyc != falls[fb+2] + 1) begin
      errors++;
      $display("FAIL basic_done_timing done at %0d, required one cycle after last fall", done_cyc);
    end
  endtask

  task automatic test_gap();
    int n;
    snapshot();
    mem[10] = {2'b10, 16'h1111};
    mem[11] = {2'b10, 16'h2222};
    do_start(9'd10, 9'd2, n);
    wait_idle(400, "gap");
    checks++;
    if (s_word.size() - sb != 2 || s_csw[sb] !== 1'b1 || s_csw[sb+1] !== 1'b1 ||
        s_word[sb] !== 16'h1111 || s_word[sb+1] !== 16'h2222) begin
      errors++;
      $display("FAIL gap_words count=%0d, required two csw strobes 1111 then 2222", s_word.size() - sb);
    end else begin
      checks++;
      if (s_cyc[sb+1] - falls[fb] != GAP_CLKS + 1) begin
        errors++;
        $display("FAIL gap_length strobe-fall distance %0d, required %0d",
                 s_cyc[sb+1] - falls[fb], GAP_CLKS + 1);
      end
    end
    checks++;
    if (done_cnt - db != 1) begin
      errors++;
      $display("FAIL gap_done pulses=%0d, required 1", done_cnt - db);
    end
  endtask

  task automatic test_bad_entry();
    int n;
    snapshot();
    mem[20] = {2'b10, 16'hAAAA};
    mem[21] = {2'b11, 16'hFFFF};
    mem[22] = {2'b01, 16'h5A5A};
    do_start(9'd20, 9'd3, n);
    wait_idle(400, "bad");
    checks++;
    if (s_word.size() - sb != 2 || s_word[sb] !== 16'hAAAA || s_word[sb+1] !== 16'h5A5A ||
        s_csw[sb] !== 1'b1 || s_csw[sb+1] !== 1'b0) begin
      errors++;
      $display("FAIL bad_skip strobe count=%0d, required csw aaaa then dw 5a5a only", s_word.size() - sb);
    end
    checks++;
    if (err !== 1'b1 || done_cnt - db != 1) begin
      errors++;
      $display("FAIL bad_err err=%b done pulses=%0d, required 1 and 1", err, done_cnt - db);
    end
  endtask

  task automatic test_zero_count();
    int n;
    snapshot();
    do_start(9'd5, 9'd0, n);
    checks++;
    if ({done, busy, mem_rd, err} !== 4'b1000) begin
      errors++;
      $display("FAIL zero_count done/busy/rd/err=%b%b%b%b, required 1000", done, busy, mem_rd, err);
    end
    @(negedge enc_clk);
    checks++;
    if (done !== 1'b0 || s_word.size() != sb) begin
      errors++;
      $display("FAIL zero_count_pulse done=%b strobes=%0d, required 0 and 0", done, s_word.size() - sb);
    end
  endtask

  task automatic test_wrap();
    int n;
    snapshot();
    mem[9'h1FF] = {2'b01, 16'h0F0F};
    do_start(9'h1FF, 9'd2, n);
    wait_idle(400, "wrap");
    checks++;
    if (rd_addr.size() - rb != 2 || rd_addr[rb] !== 9'h1FF || rd_addr[rb+1] !== 9'h000) begin
      errors++;
      $display("FAIL wrap_addrs reads=%0d first=%h second=%h, required 1ff then 000",
               rd_addr.size() - rb, rd_addr[rb], rd_addr[rb+1]);
    end
    checks++;
    if (s_word.size() - sb != 2 || s_word[sb] !== 16'h0F0F || s_word[sb+1] !== 16'h5555) begin
      errors++;
      $display("FAIL wrap_words count=%0d, required 0f0f then 5555", s_word.size() - sb);
    end
  endtask

  task automatic test_timeout();
    int n;
    snapshot();
    enc_en = 1'b0;
    mem[30] = {2'b10, 16'h7777};
    do_start(9'd30, 9'd1, n);
    wait_idle(100, "timeout");
    checks++;
    if (s_word.size() - sb != 1 || done_cnt - db != 1) begin
      errors++;
      $display("FAIL timeout_counts strobes=%0d done=%0d, required 1 and 1", s_word.size() - sb, done_cnt - db);
    end else begin
      checks++;
      if (done_cyc - s_cyc[sb] != BUSY_TO) begin
        errors++;
        $display("FAIL timeout_delay done-strobe=%0d, required %0d", done_cyc - s_cyc[sb], BUSY_TO);
      end
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err err=%b, required 1", err);
    end
    @(negedge enc_clk);
    rst = 1'b1;
    @(negedge enc_clk);
    rst = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rst_clears_err err=%b, required 0", err);
    end
    enc_en = 1'b1;
  endtask

  task automatic test_abort_rst();
    int n;
    int k;
    snapshot();
    mem[40] = {2'b10, 16'h1357};
    mem[41] = {2'b01, 16'h2468};
    do_start(9'd40, 9'd2, n);
    k = 0;
    while (!tx_busy && k < 20) begin
      @(negedge enc_clk);
      k++;
    end
    repeat (4) @(negedge enc_clk);
    abort = 1'b1;
    @(negedge enc_clk);
    abort = 1'b0;
    checks++;
    if ({mem_rd, tx_csw, tx_dw, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL abort_outputs rd/csw/dw/busy/done=%b%b%b%b%b, required 00000",
               mem_rd, tx_csw, tx_dw, busy, done);
    end
    k = 0;
    while (tx_busy && k < 100) begin
      @(negedge enc_clk);
      k++;
    end
    repeat (3) @(negedge enc_clk);
    checks++;
    if (done_cnt - db != 0 || s_word.size() - sb != 1) begin
      errors++;
      $display("FAIL abort_quiet done=%0d strobes=%0d, required 0 and 1", done_cnt - db, s_word.size() - sb);
    end

    snapshot();
    do_start(9'd10, 9'd2, n);
    k = 0;
    while (falls.size() == fb && k < 200) begin
      @(negedge enc_clk);
      k++;
    end
    repeat (5) @(negedge enc_clk);
    rst = 1'b1;
    @(negedge enc_clk);
    checks++;
    if ({mem_addr, mem_rd, tx_dword, tx_csw, tx_dw, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL rst_gap_outputs addr=%h rd=%b dword=%h csw=%b dw=%b busy=%b done=%b err=%b, required all 0",
               mem_addr, mem_rd, tx_dword, tx_csw, tx_dw, busy, done, err);
    end
    rst = 1'b0;
    repeat (30) @(negedge enc_clk);
    checks++;
    if (done_cnt - db != 0 || s_word.size() - sb != 1) begin
      errors++;
      $display("FAIL rst_gap_quiet done=%0d strobes=%0d, required 0 and 1", done_cnt - db, s_word.size() - sb);
    end

    snapshot();
    do_start(9'd10, 9'd2, n);
    wait_idle(400, "replay");
    checks++;
    if (s_word.size() - sb != 2 || s_word[sb] !== 16'h1111 || s_word[sb+1] !== 16'h2222 ||
        done_cnt - db != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL replay strobes=%0d done=%0d err=%b, required 1111,2222 one done err 0",
               s_word.size() - sb, done_cnt - db, err);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 18'h0;
    test_reset();
    test_basic();
    test_gap();
    test_bad_entry();
    test_zero_count();
    test_wrap();
    test_timeout();
    test_abort_rst();
    checks++;
    if (bad_dword != 0) begin
      errors++;
      $display("FAIL dword_idle_zero nonzero tx_dword without strobe in %0d cycles, required 0", bad_dword);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
